ch_accum_buf: RTL
=================

// Module: ch_accum_buf
// PURPOSE
//  Downstream of conv_blk: sums its per-input-channel result stream (o_en/o_conv_result) over
//  IN_FM_CH passes into one output-channel feature map, held in an on-chip buffer.
//  After the last pass it streams the summed map to the output-FM BRAM writer via valid/ready.
// PARAMETERS
//  DW        `DW        signed width of data in, accumulators and data out
//  IN_FM_CH  `IN_FM_CH  input-channel passes summed per output channel (>=1)
//  N_PIX     169        results per pass (OUT_SIZE^2, or (OUT_SIZE/2)^2 with MAXPOOL); >=2
//  AW        $clog2(N_PIX)  buffer address width
// PORTS
//  i_clk    in   1      clock
//  i_rst    in   1      sync reset, active high
//  i_start  in   1      pulse: begin new output-channel accumulation (honoured in IDLE only)
//  i_en     in   1      conv_blk result valid (no backpressure upstream)
//  i_data   in   DW     conv_blk result, signed
//  o_busy   out  1      high in ACCUM or DRAIN
//  o_valid  out  1      output word valid
//  o_data   out  DW     summed result, signed, raster order
//  o_last   out  1      with o_valid on final word (index N_PIX-1)
//  i_ready  in   1      consumer accepts word when o_valid && i_ready
//  o_done   out  1      one-cycle pulse after final handshake
//  o_ovf    out  1      sticky: a sum saturated; cleared by i_start or reset
//  o_drop   out  1      sticky: i_en seen outside ACCUM; cleared by i_start or reset
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pix_cnt=ch_cnt=0. Buffer contents not cleared.
//  FSM IDLE -> ACCUM on i_start; ACCUM -> DRAIN when final write of ch IN_FM_CH-1 commits;
//   DRAIN -> IDLE after handshake of index N_PIX-1 (o_done pulses the next cycle).
//  ACCUM: each i_en word = pixel pix_cnt of channel ch_cnt. pix_cnt wraps N_PIX-1 -> 0 and
//   increments ch_cnt. Bubbles (i_en low) are allowed anywhere; counters hold.
//  RMW pipeline: cycle t i_en -> read buf[pix]; t+1 add; buffer write committed by t+2.
//   ch_cnt==0: write i_data directly (no add), so stale buffer contents never leak.
//   Consecutive addresses always differ (N_PIX>=2); no read/write bypass required.
//  Arithmetic: DW+1-bit sum, saturate to [-2^(DW-1), 2^(DW-1)-1]; any clamp sets o_ovf.
//  DRAIN: first o_valid no later than 3 cycles after final write; o_data/o_last held stable
//   while o_valid && !i_ready; with i_ready held high, one word per cycle, no gaps.
//  i_en in IDLE/DRAIN: word discarded, o_drop set, buffer untouched.
//  i_start outside IDLE: ignored. i_start and i_en same cycle in IDLE: i_en word dropped.
//  Reset mid-ACCUM/DRAIN: immediate return to IDLE, o_valid low next cycle, partial map discarded.
// STRUCTURE
//  global.v: reuse `DW, `IN_FM_CH; add `ACC_N_PIX default and FSM state encodings.
//  Sub-module accum_ram: simple dual-port RAM, N_PIX x DW, 1 write + 1 registered read port.
//  FSM, counters, saturating adder and output register stay in ch_accum_buf.
// TESTING
//  1 IN_FM_CH=3,N_PIX=4: ch0{1,2,3,4} ch1{10,20,30,40} ch2{-1,-2,-3,-4}, i_ready=1
//    -> o_data 10,20,30,40, o_last on 40, o_done 1 cycle later, o_ovf=0.
//  2 Same stimulus, i_ready toggling 1,0,0,1,... -> identical sequence, each word once, stable while stalled.
//  3 DW=16: ch0{30000,-30000} ch1{30000,-30000}, IN_FM_CH=2 -> 32767,-32768, o_ovf=1 until next i_start.
//  4 i_en=1 data 99 in IDLE -> o_drop=1, no o_valid; then run test 1 -> results unaffected by 99.
//  5 Reset after 5 words of test 1, then i_start + full test 1 -> 10,20,30,40 (no leftover state).
//  6 Test 1 with random 0-3 cycle bubbles between i_en words -> 10,20,30,40.

Source files
------------

// File: rtl/ch_accum_buf_pkg.sv
// Shared defaults and FSM encoding for the output-channel accumulation buffer.
package ch_accum_buf_pkg;
    localparam int ACC_DW       = 16;
    localparam int ACC_IN_FM_CH = 3;
    localparam int ACC_N_PIX    = 169;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/ch_accum_buf_ram.sv
// Simple dual-port buffer: one write port, one registered read port.
module ch_accum_buf_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 169,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Read data holds between reads so the drain logic can park on it.
    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ch_accum_buf.sv
// Sums IN_FM_CH passes of N_PIX conv results into one map, then streams it out via valid/ready.
module ch_accum_buf
    import ch_accum_buf_pkg::*;
#(
    parameter int DW       = ACC_DW,
    parameter int IN_FM_CH = ACC_IN_FM_CH,
    parameter int N_PIX    = ACC_N_PIX,
    parameter int AW       = $clog2(N_PIX)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_en,
    input  logic [DW-1:0] i_data,
    output logic          o_busy,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    input  logic          i_ready,
    output logic          o_done,
    output logic          o_ovf,
    output logic          o_drop,
    output logic [1:0]    dbg_state
);
    localparam int CW = $clog2(IN_FM_CH + 1);
    localparam logic [AW-1:0] LAST_PIX = AW'(N_PIX - 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(IN_FM_CH - 1);

    // Output handshake: a word transfers on any rising edge where o_valid && i_ready;
    // o_data/o_last never change while o_valid is high and i_ready is low.

    state_t state, state_nx;
    logic [AW-1:0] pix_cnt;
    logic [CW-1:0] ch_cnt;
    logic          in_full;
    logic          take;
    logic          s1_valid, s1_first, s1_last;
    logic [AW-1:0] s1_pix;
    logic [DW-1:0] s1_data;
    logic [DW:0]   sum;
    logic          sat_hit;
    logic [DW-1:0] sat_val;
    logic          rd_en, wr_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data, wr_data;
    logic [AW-1:0] dr_ptr;
    logic          dr_all, q_valid, q_last, o_move, dr_issue, final_hs;

    assign take     = (state == ST_ACCUM) && i_en && !in_full;
    assign o_move   = q_valid && (!o_valid || i_ready);
    assign dr_issue = (state == ST_DRAIN) && !dr_all && (!q_valid || o_move);
    assign final_hs = (state == ST_DRAIN) && o_valid && i_ready && o_last;
    assign rd_en    = take || dr_issue;
    assign rd_addr  = take ? pix_cnt : dr_ptr;
    assign o_busy   = (state != ST_IDLE);
    assign dbg_state = state;

    always_comb begin
        sum     = {rd_data[DW-1], rd_data} + {s1_data[DW-1], s1_data};
        sat_hit = sum[DW] ^ sum[DW-1];
        sat_val = sum[DW-1:0];
        if (sat_hit) sat_val = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        wr_en   = s1_valid;
        wr_data = s1_first ? s1_data : sat_val;
    end

    ch_accum_buf_ram #(.DW(DW), .DEPTH(N_PIX), .AW(AW)) u_ram (
        .i_clk (i_clk),
        .we    (wr_en),
        .waddr (s1_pix),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (i_start) state_nx = ST_ACCUM;
            ST_ACCUM: if (s1_valid && s1_last) state_nx = ST_DRAIN;
            ST_DRAIN: if (final_hs) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Input counters and the read-modify-write stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pix_cnt  <= '0;
            ch_cnt   <= '0;
            in_full  <= 1'b0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_pix   <= '0;
            s1_data  <= '0;
            o_ovf    <= 1'b0;
            o_drop   <= 1'b0;
        end else begin
            if (state == ST_IDLE && i_start) begin
                pix_cnt <= '0;
                ch_cnt  <= '0;
                in_full <= 1'b0;
                o_ovf   <= 1'b0;
                o_drop  <= 1'b0;
            end
            s1_valid <= take;
            if (take) begin
                s1_pix   <= pix_cnt;
                s1_data  <= i_data;
                s1_first <= (ch_cnt == '0);
                s1_last  <= (ch_cnt == LAST_CH) && (pix_cnt == LAST_PIX);
                if (pix_cnt == LAST_PIX) begin
                    pix_cnt <= '0;
                    if (ch_cnt == LAST_CH) in_full <= 1'b1;
                    else                   ch_cnt  <= ch_cnt + 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
            if (s1_valid && !s1_first && sat_hit) o_ovf <= 1'b1;
            // A dropped word wins over the clear so a same-cycle start still reports it.
            if (i_en && !take) o_drop <= 1'b1;
        end
    end

    // Drain: issue reads into a one-word holding stage (the RAM read register), then the output register.
    always_ff @(posedge i_clk) begin
        if (i_rst || state != ST_DRAIN) begin
            dr_ptr  <= '0;
            dr_all  <= 1'b0;
            q_valid <= 1'b0;
            q_last  <= 1'b0;
        end else begin
            if (dr_issue) begin
                dr_ptr  <= dr_ptr + 1'b1;
                dr_all  <= (dr_ptr == LAST_PIX);
                q_valid <= 1'b1;
                q_last  <= (dr_ptr == LAST_PIX);
            end else if (o_move) begin
                q_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= final_hs;
            if (o_move) begin
                o_valid <= 1'b1;
                o_data  <= rd_data;
                o_last  <= q_last;
            end else if (i_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end
endmodule
